// File: rtl/spi_slave.sv
//------------------------------------------------------------------------------
// spi_slave : SPI mode-0 slave that exchanges one DATA_WIDTH-bit frame per
//             chip-select with a double-buffered transmit word.
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module spi_slave #(
    parameter int DATA_WIDTH  = 128,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int c_cnt_w = $clog2(DATA_WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_WIDTH - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;

    logic [DATA_WIDTH-1:0]  r_tx_buf;
    logic [DATA_WIDTH-1:0]  r_shreg;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_miso;

    logic w_sclk, w_cs, w_mosi;
    logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
    logic w_start, w_abort, w_done, w_shift_in, w_advance, w_load_buf;
    logic [DATA_WIDTH-1:0] w_load_word;

    // Chip select idles high so its chain resets to 1 and no false fall appears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync[0] <= sclk;
            r_cs_sync[0]   <= cs_n;
            r_mosi_sync[0] <= mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sclk_sync[i] <= r_sclk_sync[i-1];
                r_cs_sync[i]   <= r_cs_sync[i-1];
                r_mosi_sync[i] <= r_mosi_sync[i-1];
            end
            r_sclk_d <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_d   <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_cs_rise   = w_cs & ~r_cs_d;
    assign w_cs_fall   = ~w_cs & r_cs_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_cs_fall) begin
                    w_state_nxt = c_st_shift;
                end
            end
            c_st_shift: begin
                if (w_cs_rise) begin
                    w_state_nxt = c_st_idle;
                end else if (w_sclk_rise && (r_cnt == c_last_bit)) begin
                    w_state_nxt = c_st_wait;
                end
            end
            c_st_wait: begin
                if (w_cs_rise) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // A cs_n rise in SHIFT always wins over a coincident sclk edge.
    always_comb begin
        w_start    = (r_state == c_st_idle) && w_cs_fall;
        w_load_buf = (r_state == c_st_idle) && tx_load;
        w_abort    = (r_state == c_st_shift) && w_cs_rise;
        w_shift_in = (r_state == c_st_shift) && !w_cs_rise && w_sclk_rise;
        w_advance  = (r_state == c_st_shift) && !w_cs_rise && w_sclk_fall;
        w_done     = w_shift_in && (r_cnt == c_last_bit);
        busy       = (r_state != c_st_idle);
        tx_ready   = (r_state == c_st_idle);
        miso       = (r_state == c_st_shift) && r_miso;
    end

    assign w_load_word = tx_load ? tx_data : r_tx_buf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_buf  <= '0;
            r_shreg   <= '0;
            r_cnt     <= '0;
            r_miso    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= w_done;
            frame_err <= w_abort;
            if (w_load_buf) begin
                r_tx_buf <= tx_data;
            end
            if (w_done) begin
                rx_data <= {r_shreg[DATA_WIDTH-2:0], w_mosi};
            end
            if (w_start) begin
                r_shreg <= w_load_word;
                r_cnt   <= '0;
                r_miso  <= w_load_word[DATA_WIDTH-1];
            end else begin
                if (w_shift_in) begin
                    r_shreg <= {r_shreg[DATA_WIDTH-2:0], w_mosi};
                    r_cnt   <= r_cnt + 1'b1;
                end
                // The rise already moved the next transmit bit into the MSB.
                if (w_advance) begin
                    r_miso <= r_shreg[DATA_WIDTH-1];
                end
            end
        end
    end

endmodule

`default_nettype wire
